mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the eLC-3 datapath's MIO_EN / R_W / MAR / MDR request interface.
- Services each access either from external asynchronous SRAM (with programmable wait states) or from memory-mapped I/O registers.
- Signals completion to the control FSM with the LC-3 ready signal R.
- Sits between the datapath and the board SRAM/keyboard/display pins.

Parameters:
- WAIT_CYCLES, 2: SRAM access cycles per transfer (>=1).
- IO_BASE, 16'hFE00: first address of the I/O page (FE00–FFFF are never SRAM).

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- MIO_EN  in  1  access request from the control FSM
- R_W  in  1  1 = write, 0 = read
- Addr  in  16  MAR contents
- Data_In  in  16  MDR contents (write data)
- Data_Out  out  16  read data to the MDR input mux
- R  out  1  access complete (one-cycle pulse)
- SRAM_Addr  out  16  SRAM address
- SRAM_DQ_Out  out  16  SRAM write data
- SRAM_DQ_In  in  16  SRAM read data
- SRAM_DQ_OE  out  1  tri-state enable for SRAM_DQ_Out
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  out  1 each  SRAM strobes, active-low
- KB_Data  in  8  keyboard character
- KB_Valid  in  1  one-cycle strobe: KB_Data is new
- Disp_Ready  in  1  display can accept a character
- DDR_Data  out  8  character to display
- DDR_Strobe  out  1  one-cycle pulse: DDR_Data is new
- Run  out  1  MCR[15], machine clock enable

Behaviour:
- Reset values:
  - FSM = IDLE; R = 0; Data_Out = 0.
  - SRAM_CE_N = SRAM_OE_N = SRAM_WE_N = 1; SRAM_DQ_OE = 0; SRAM_Addr = 0; SRAM_DQ_Out = 0.
  - KBSR = 0; KBDR = 0; DDR_Data = 0; DDR_Strobe = 0; Run = 1.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If MIO_EN = 1 at the clock edge, latch Addr, R_W and Data_In.
  - If Addr >= IO_BASE, go to DONE; otherwise go to ACCESS and load the wait counter with WAIT_CYCLES-1.
  - MIO_EN = 0: stay in IDLE.
- ACCESS:
  - SRAM_CE_N = 0; SRAM_Addr = latched address.
  - Read: SRAM_OE_N = 0; on the final ACCESS cycle, capture SRAM_DQ_In into Data_Out.
  - Write: SRAM_WE_N = 0, SRAM_DQ_OE = 1, SRAM_DQ_Out = latched data.
  - Counter decrements each cycle; at 0, go to DONE.
- DONE:
  - R = 1 for exactly this cycle.
  - SRAM_WE_N and SRAM_OE_N return to 1; SRAM_CE_N, SRAM_DQ_OE, address and data hold for one cycle.
  - Next state is always IDLE.
  - MIO_EN still high in the following IDLE cycle is treated as a new request.
- Latency, with MIO_EN sampled at edge k:
  - SRAM access: R high in cycle k+WAIT_CYCLES+1.
  - I/O access: R high in cycle k+1.
- Data_Out holds its value until the next read completes; writes never change it.
- I/O map (reads complete in DONE, values registered into Data_Out):
  - FE00 KBSR: bit15 = ready, bit14 = interrupt enable (R/W); other bits read 0.
  - FE02 KBDR: {8'h00, KBDR}. A read clears KBSR[15]. Writes ignored.
  - FE04 DSR: bit15 = Disp_Ready & ~DDR_Strobe. Writes ignored.
  - FE06 DDR: a write sets DDR_Data = Data_In[7:0] and pulses DDR_Strobe in the DONE cycle. Reads return {8'h00, DDR_Data}.
  - FFFE MCR: bit15 = Run. A write sets Run = Data_In[15].
  - Any other address >= IO_BASE: reads return 0, writes ignored, still one-cycle latency.
- Keyboard capture:
  - KB_Valid (any state) latches KB_Data into KBDR and sets KBSR[15].
  - KB_Valid in the same cycle as a KBDR read: new data loads, flag stays 1 (set wins over clear). The read returns the old data.
  - KB_Valid while the flag is already set: overwrite (overrun); flag stays 1.
- Reset mid-access: immediate return to reset values; no R pulse; an in-flight SRAM write is abandoned (WE_N released asynchronously).

Decomposition:
- Package elc3_mem_pkg:
  - state enum (IDLE, ACCESS, DONE);
  - address constants ADDR_KBSR, ADDR_KBDR, ADDR_DSR, ADDR_DDR, ADDR_MCR.
- Sub-module mem_io_regs holds KBSR/KBDR/DDR/MCR, keyboard capture and the DDR_Strobe pulse.
- The top level contains the FSM, wait counter and SRAM drive.

Test Plan:
- SRAM read, WAIT_CYCLES=2: SRAM model returns 16'h1234 at 16'h3000; MIO_EN=1, R_W=0, Addr=3000 at edge k -> OE_N low cycles k+1..k+2, R=1 only in cycle k+3, Data_Out=1234.
- SRAM write: Addr=0x0040, Data_In=0xBEEF -> WE_N low exactly 2 cycles, DQ_OE=1 through DONE, model holds 0xBEEF, Data_Out unchanged.
- Keyboard: KB_Valid with KB_Data=0x41; read FE00 -> 0x8000; read FE02 -> 0x0041; read FE00 again -> 0x0000. KB_Valid on the same edge as a FE02 read -> KBSR[15] stays 1.
- Display: write 0x0058 to FE06 -> DDR_Data=0x58, DDR_Strobe high one cycle (DONE), R in cycle k+1. With Disp_Ready=1, a read of FE04 returns 0x8000.
- MCR and unmapped: write 0x0000 to FFFE -> Run=0. Read FE10 -> Data_Out=0, R in cycle k+1.
- Reset mid-write: assert Reset during the first ACCESS cycle -> WE_N, CE_N = 1 and R = 0 immediately; the FSM accepts a fresh read normally after Reset is released.

Source files
------------

// File: rtl/elc3_mem_pkg.sv
// Shared types for the eLC-3 memory responder.
// Holds the FSM state enum and the I/O page register addresses.
package elc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;
  localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

endpackage

// File: rtl/mem_io_regs.sv
// Memory-mapped I/O registers: KBSR/KBDR, DSR, DDR, MCR.
// Ports: clk/rst, access strobe (acc/we/addr/wdata), keyboard in,
// display ready in, read data out, DDR data/strobe out, Run out.
module mem_io_regs
  import elc3_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        acc,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [7:0]  kb_data,
  input  logic        kb_valid,
  input  logic        disp_ready,
  output logic [15:0] rdata,
  output logic [7:0]  ddr_data,
  output logic        ddr_strobe,
  output logic        run
);

  logic       kb_rdy_q, kb_rdy_d;
  logic       kb_ie_q, kb_ie_d;
  logic [7:0] kbdr_q, kbdr_d;
  logic [7:0] ddr_q, ddr_d;
  logic       stb_q, stb_d;
  logic       run_q, run_d;
  logic       rd, wr;
  logic       unused_wdata;

  assign unused_wdata = ^wdata[13:8];
  assign rd = acc & ~we;
  assign wr = acc & we;

  always_comb begin
    rdata = 16'h0000;
    unique case (1'b1)
      (addr == ADDR_KBSR): rdata = {kb_rdy_q, kb_ie_q, 14'h0};
      (addr == ADDR_KBDR): rdata = {8'h00, kbdr_q};
      (addr == ADDR_DSR):  rdata = {disp_ready & ~stb_q, 15'h0};
      (addr == ADDR_DDR):  rdata = {8'h00, ddr_q};
      (addr == ADDR_MCR):  rdata = {run_q, 15'h0};
      default:             rdata = 16'h0000;
    endcase
  end

  always_comb begin
    kb_rdy_d = kb_rdy_q;
    kb_ie_d  = kb_ie_q;
    kbdr_d   = kbdr_q;
    ddr_d    = ddr_q;
    stb_d    = 1'b0;
    run_d    = run_q;
    // a new keystroke wins over the clear from a KBDR read
    if (rd && addr == ADDR_KBDR) kb_rdy_d = 1'b0;
    if (kb_valid) begin
      kb_rdy_d = 1'b1;
      kbdr_d   = kb_data;
    end
    if (wr && addr == ADDR_KBSR) kb_ie_d = wdata[14];
    if (wr && addr == ADDR_DDR) begin
      ddr_d = wdata[7:0];
      stb_d = 1'b1;
    end
    if (wr && addr == ADDR_MCR) run_d = wdata[15];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kb_rdy_q <= 1'b0;
      kb_ie_q  <= 1'b0;
      kbdr_q   <= 8'h00;
      ddr_q    <= 8'h00;
      stb_q    <= 1'b0;
      run_q    <= 1'b1;
    end else begin
      kb_rdy_q <= kb_rdy_d;
      kb_ie_q  <= kb_ie_d;
      kbdr_q   <= kbdr_d;
      ddr_q    <= ddr_d;
      stb_q    <= stb_d;
      run_q    <= run_d;
    end
  end

  assign ddr_data   = ddr_q;
  assign ddr_strobe = stb_q;
  assign run        = run_q;

endmodule

// File: rtl/mem_responder.sv
// eLC-3 memory responder: SRAM with wait states or I/O page access.
// Ports: Clk/Reset, MIO_EN/R_W/Addr/Data_In request, Data_Out/R reply,
// SRAM address/data/strobes, keyboard/display pins, Run.
module mem_responder
  import elc3_mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_BASE     = 16'hFE00
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic [15:0] Addr,
  input  logic [15:0] Data_In,
  output logic [15:0] Data_Out,
  output logic        R,
  output logic [15:0] SRAM_Addr,
  output logic [15:0] SRAM_DQ_Out,
  input  logic [15:0] SRAM_DQ_In,
  output logic        SRAM_DQ_OE,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  input  logic [7:0]  KB_Data,
  input  logic        KB_Valid,
  input  logic        Disp_Ready,
  output logic [7:0]  DDR_Data,
  output logic        DDR_Strobe,
  output logic        Run
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e          state_q, state_d;
  logic            rw_q, rw_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            r_q, r_d;
  logic [15:0]     dout_q, dout_d;
  logic            ce_n_q, ce_n_d;
  logic            oe_n_q, oe_n_d;
  logic            we_n_q, we_n_d;
  logic            dq_oe_q, dq_oe_d;
  logic [15:0]     saddr_q, saddr_d;
  logic [15:0]     sdq_q, sdq_d;
  logic            is_io;
  logic            io_acc;
  logic [15:0]     io_rdata;

  assign is_io  = (Addr >= IO_BASE);
  assign io_acc = (state_q == IDLE) & MIO_EN & is_io;

  mem_io_regs u_io (
    .clk       (Clk),
    .rst       (Reset),
    .acc       (io_acc),
    .we        (R_W),
    .addr      (Addr),
    .wdata     (Data_In),
    .kb_data   (KB_Data),
    .kb_valid  (KB_Valid),
    .disp_ready(Disp_Ready),
    .rdata     (io_rdata),
    .ddr_data  (DDR_Data),
    .ddr_strobe(DDR_Strobe),
    .run       (Run)
  );

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    cnt_d   = cnt_q;
    r_d     = 1'b0;
    dout_d  = dout_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    dq_oe_d = dq_oe_q;
    saddr_d = saddr_q;
    sdq_d   = sdq_q;
    unique case (state_q)
      IDLE: begin
        if (MIO_EN) begin
          rw_d = R_W;
          if (is_io) begin
            state_d = DONE;
            r_d     = 1'b1;
            if (!R_W) dout_d = io_rdata;
          end else begin
            // strobes are registered, so they go active with ACCESS
            state_d = ACCESS;
            cnt_d   = CW'(WAIT_CYCLES - 1);
            ce_n_d  = 1'b0;
            oe_n_d  = R_W;
            we_n_d  = ~R_W;
            dq_oe_d = R_W;
            saddr_d = Addr;
            if (R_W) sdq_d = Data_In;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          r_d     = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          if (!rw_q) dout_d = SRAM_DQ_In;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        ce_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      cnt_q   <= '0;
      r_q     <= 1'b0;
      dout_q  <= 16'h0000;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      saddr_q <= 16'h0000;
      sdq_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      dout_q  <= dout_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      dq_oe_q <= dq_oe_d;
      saddr_q <= saddr_d;
      sdq_q   <= sdq_d;
    end
  end

  assign Data_Out    = dout_q;
  assign R           = r_q;
  assign SRAM_Addr   = saddr_q;
  assign SRAM_DQ_Out = sdq_q;
  assign SRAM_DQ_OE  = dq_oe_q;
  assign SRAM_CE_N   = ce_n_q;
  assign SRAM_OE_N   = oe_n_q;
  assign SRAM_WE_N   = we_n_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder.
// Directed accesses; a monitor checks Data_Out and R timing.
module tb_mem_responder;

  logic        Clk;
  logic        Reset;
  logic        MIO_EN;
  logic        R_W;
  logic [15:0] Addr;
  logic [15:0] Data_In;
  logic [15:0] Data_Out;
  logic        R;
  logic [15:0] SRAM_Addr;
  logic [15:0] SRAM_DQ_Out;
  logic [15:0] SRAM_DQ_In;
  logic        SRAM_DQ_OE;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;
  logic [7:0]  KB_Data;
  logic        KB_Valid;
  logic        Disp_Ready;
  logic [7:0]  DDR_Data;
  logic        DDR_Strobe;
  logic        Run;

  mem_responder #(.WAIT_CYCLES(2), .IO_BASE(16'hFE00)) dut (
    .Clk(Clk), .Reset(Reset), .MIO_EN(MIO_EN), .R_W(R_W),
    .Addr(Addr), .Data_In(Data_In), .Data_Out(Data_Out), .R(R),
    .SRAM_Addr(SRAM_Addr), .SRAM_DQ_Out(SRAM_DQ_Out),
    .SRAM_DQ_In(SRAM_DQ_In), .SRAM_DQ_OE(SRAM_DQ_OE),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N), .KB_Data(KB_Data), .KB_Valid(KB_Valid),
    .Disp_Ready(Disp_Ready), .DDR_Data(DDR_Data),
    .DDR_Strobe(DDR_Strobe), .Run(Run)
  );

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] mem [0:4095];
  int          cyc;
  int          tests;
  int          fails;
  int          oe_cnt, we_cnt, dqoe_cnt, stb_cnt;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  assign SRAM_DQ_In = (!SRAM_CE_N && !SRAM_OE_N) ?
                      mem[SRAM_Addr[11:0]] : 16'hDEAD;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic req(input logic rw, input logic [15:0] a,
                     input logic [15:0] d, input logic [15:0] exp,
                     input int lat, input logic kbv,
                     input logic [7:0] kbd);
    exp_t e;
    @(negedge Clk);
    MIO_EN = 1'b1; R_W = rw; Addr = a; Data_In = d;
    if (kbv) begin KB_Valid = 1'b1; KB_Data = kbd; end
    @(posedge Clk);
    #1;
    e.data = exp;
    e.cyc  = cyc + lat;
    sbq.push_back(e);
    oe_cnt = 0; we_cnt = 0; dqoe_cnt = 0; stb_cnt = 0;
    for (int i = 0; i < lat + 2; i++) begin
      @(negedge Clk);
      if (i == 0) begin MIO_EN = 1'b0; KB_Valid = 1'b0; end
      if (!SRAM_OE_N) oe_cnt++;
      if (!SRAM_WE_N) we_cnt++;
      if (SRAM_DQ_OE) dqoe_cnt++;
      if (DDR_Strobe) stb_cnt++;
    end
  endtask

  initial begin
    exp_t e;
    tests = 0; fails = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h000] = 16'h1234;
    Reset = 1'b1; MIO_EN = 1'b0; R_W = 1'b0; Addr = 16'h0;
    Data_In = 16'h0; KB_Data = 8'h0; KB_Valid = 1'b0;
    Disp_Ready = 1'b0;

    fork
      forever begin
        @(negedge Clk);
        if (!Reset && R) begin
          if (sbq.size() == 0) begin
            chk("unexpected_R", {16'h0, Data_Out}, 32'hFFFF_FFFF);
          end else begin
            e = sbq.pop_front();
            chk("data_out", {16'h0, Data_Out}, {16'h0, e.data});
            chk("r_cycle", cyc, e.cyc);
          end
        end
      end
      forever begin
        @(posedge Clk);
        if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_OE)
          mem[SRAM_Addr[11:0]] = SRAM_DQ_Out;
      end
    join_none

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_r_dout", {15'h0, R, Data_Out}, 32'h0);
    chk("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE},
        32'hE);
    chk("rst_sram_bus", {SRAM_Addr, SRAM_DQ_Out}, 32'h0);
    chk("rst_io", {DDR_Data, DDR_Strobe, Run}, {8'h00, 1'b0, 1'b1});
    @(negedge Clk);
    Reset = 1'b0;

    req(1'b0, 16'h3000, 16'h0, 16'h1234, 2, 1'b0, 8'h0);
    chk("rd_oe_cycles", oe_cnt, 2);
    chk("rd_we_cycles", we_cnt, 0);
    req(1'b1, 16'h0040, 16'hBEEF, 16'h1234, 2, 1'b0, 8'h0);
    chk("wr_we_cycles", we_cnt, 2);
    chk("wr_dqoe_cycles", dqoe_cnt, 3);
    chk("wr_mem", {16'h0, mem[12'h040]}, 32'hBEEF);

    @(negedge Clk);
    KB_Valid = 1'b1; KB_Data = 8'h41;
    @(negedge Clk);
    KB_Valid = 1'b0;
    req(1'b0, 16'hFE00, 16'h0, 16'h8000, 0, 1'b0, 8'h0);
    req(1'b0, 16'hFE02, 16'h0, 16'h0041, 0, 1'b0, 8'h0);
    req(1'b0, 16'hFE00, 16'h0, 16'h0000, 0, 1'b0, 8'h0);
    req(1'b0, 16'hFE02, 16'h0, 16'h0041, 0, 1'b1, 8'h42);
    req(1'b0, 16'hFE00, 16'h0, 16'h8000, 0, 1'b0, 8'h0);
    req(1'b0, 16'hFE02, 16'h0, 16'h0042, 0, 1'b0, 8'h0);
    req(1'b1, 16'hFE00, 16'h4000, 16'h0042, 0, 1'b0, 8'h0);
    req(1'b0, 16'hFE00, 16'h0, 16'h4000, 0, 1'b0, 8'h0);

    Disp_Ready = 1'b1;
    req(1'b1, 16'hFE06, 16'h0058, 16'h4000, 0, 1'b0, 8'h0);
    chk("ddr_strobe_cycles", stb_cnt, 1);
    chk("ddr_data", {24'h0, DDR_Data}, 32'h58);
    req(1'b0, 16'hFE04, 16'h0, 16'h8000, 0, 1'b0, 8'h0);
    req(1'b0, 16'hFE06, 16'h0, 16'h0058, 0, 1'b0, 8'h0);

    req(1'b1, 16'hFFFE, 16'h0000, 16'h0058, 0, 1'b0, 8'h0);
    chk("run_cleared", {31'h0, Run}, 32'h0);
    req(1'b0, 16'hFFFE, 16'h0, 16'h0000, 0, 1'b0, 8'h0);
    req(1'b0, 16'hFE04, 16'h0, 16'h8000, 0, 1'b0, 8'h0);
    req(1'b0, 16'hFE10, 16'h0, 16'h0000, 0, 1'b0, 8'h0);

    @(negedge Clk);
    MIO_EN = 1'b1; R_W = 1'b1; Addr = 16'h0100; Data_In = 16'h5555;
    @(posedge Clk);
    #1;
    MIO_EN = 1'b0;
    chk("mid_we_active", {31'h0, SRAM_WE_N}, 32'h0);
    Reset = 1'b1;
    #1;
    chk("mid_rst_pins", {SRAM_WE_N, SRAM_CE_N, R}, {1'b1, 1'b1, 1'b0});
    chk("mid_rst_dout", {16'h0, Data_Out}, 32'h0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    chk("mid_rst_mem", {16'h0, mem[12'h100]}, 32'h0);

    req(1'b0, 16'h3000, 16'h0, 16'h1234, 2, 1'b0, 8'h0);
    repeat (4) @(negedge Clk);
    chk("sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
